// File: rtl/snes_pad_responder.sv
// snes_pad_responder
//   Presents a 16-bit live button state as a SNES-style serial gamepad.
//   The core is the initiator and drives pad_latch and pad_clk. This block
//   is the responder: it returns 16 active-low bits, bit 0 first.
//   pad_latch and pad_clk may be asynchronous to clk, so each one is
//   synchronized and edge-detected here.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on pad_latch and pad_clk (2..4)
//
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   key[15:0]   live button state, 1 = pressed
//               (0 up, 1 down, 2 left, 3 right, 4 A, 5 B, 6 X, 7 Y,
//                8 L1, 9 R1, 14 select, 15 start)
//   pad_latch   core latch strobe, active high
//   pad_clk     core shift clock; idles high, shifts on its rising edge
//   pad_data_n  serial data out, active low (registered)
//   busy        high from latch fall until bit 16 has been shifted
//   bit_idx     index of the bit currently on pad_data_n, 0..16
module snes_pad_responder #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] key,
   input  logic        pad_latch,
   input  logic        pad_clk,
   output logic        pad_data_n,
   output logic        busy,
   output logic [4:0]  bit_idx
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LATCH = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
   logic [SYNC_STAGES-1:0] clk_sync_q,   clk_sync_d;
   logic                   latch_hist_q, latch_hist_d;
   logic                   clk_hist_q,   clk_hist_d;
   logic [1:0]             state_q,      state_d;
   logic [15:0]            shift_q,      shift_d;
   logic [4:0]             bit_idx_q,    bit_idx_d;
   logic                   busy_q,       busy_d;
   logic                   pad_data_n_q, pad_data_n_d;

   logic                   latch_s;
   logic                   latch_fall;
   logic                   clk_rise;
   logic [15:0]            wire_word;
   logic                   unused_keys;

   // Controller keys reordered into wire order and inverted; the top four
   // bits are the fixed "not pressed" ID bits.
   assign wire_word = {4'b1111,
                       ~key[9], ~key[8], ~key[6], ~key[4],
                       ~key[3], ~key[2], ~key[1], ~key[0],
                       ~key[15], ~key[14], ~key[7], ~key[5]};

   // Keys 10..13 have no slot on the SNES wire.
   assign unused_keys = ^key[13:10];

   assign latch_s    = latch_sync_q[SYNC_STAGES-1];
   assign latch_fall = ~latch_s & latch_hist_q;
   assign clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;

   always_comb begin
      latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad_latch};
      clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
      latch_hist_d = latch_s;
      clk_hist_d   = clk_sync_q[SYNC_STAGES-1];

      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      busy_d       = busy_q;
      pad_data_n_d = pad_data_n_q;

      // Latch level dominates everything, including a same-cycle clock rise;
      // a clock rise coinciding with the latch fall is dropped as well.
      if (latch_s) begin
         state_d      = ST_LATCH;
         shift_d      = wire_word;
         bit_idx_d    = '0;
         busy_d       = 1'b0;
         pad_data_n_d = wire_word[0];
      end else if (latch_fall) begin
         state_d = ST_SHIFT;
         busy_d  = 1'b1;
      end else if (state_q == ST_SHIFT && clk_rise) begin
         shift_d      = {1'b0, shift_q[15:1]};
         bit_idx_d    = bit_idx_q + 5'd1;
         pad_data_n_d = shift_q[1];
         if (bit_idx_q == 5'd15) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         latch_sync_q <= '0;
         clk_sync_q   <= '1;
         latch_hist_q <= 1'b0;
         clk_hist_q   <= 1'b1;
         state_q      <= ST_IDLE;
         shift_q      <= '1;
         bit_idx_q    <= '0;
         busy_q       <= 1'b0;
         pad_data_n_q <= 1'b1;
      end else begin
         latch_sync_q <= latch_sync_d;
         clk_sync_q   <= clk_sync_d;
         latch_hist_q <= latch_hist_d;
         clk_hist_q   <= clk_hist_d;
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         busy_q       <= busy_d;
         pad_data_n_q <= pad_data_n_d;
      end
   end

   assign pad_data_n = pad_data_n_q;
   assign busy       = busy_q;
   assign bit_idx    = bit_idx_q;

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Presents the Pocket controller state as a standard SNES-style serial gamepad, so cores that poll a pad can read it.
- The core acts as the initiator and drives latch and pad clock; this block is the responder and shifts out 16 active-low button bits.
- It sits between the controller state (pocket::key_t from the bridge) and the core's pad-port pins.
- Core-side strobes may be asynchronous to clk, so they are synchronized internally.

Parameters:
- SYNC_STAGES, 2: flop stages on pad_latch and pad_clk before edge detection. Legal range 2..4.

Ports:
- clk  input  1  system clock; all logic is synchronous to it.
- reset_n  input  1  synchronous, active-low reset.
- key  input  16 (pocket::key_t)  live button state, 1 = pressed. Bit map: 0 up, 1 down, 2 left, 3 right, 4 A, 5 B, 6 X, 7 Y, 8 L1, 9 R1, 14 select, 15 start.
- pad_latch  input  1  core latch strobe, active high.
- pad_clk  input  1  core shift clock; idles high, shifts on rising edge.
- pad_data_n  output  1  serial data, active low (0 = pressed).
- busy  output  1  high from latch fall until bit 16 is shifted.
- bit_idx  output  5  index of the bit currently on pad_data_n, 0..16.

Behaviour:
- **Reset.** While reset_n = 0 at a clk edge:
  - state = IDLE, pad_data_n = 1, busy = 0, bit_idx = 0, shift register = 16'hFFFF.
  - All synchronizer stages cleared: latch chain to 0, pad_clk chain to 1.
  - Reset mid-shift aborts the transfer with no partial output.
- **Synchronizers.** pad_latch and pad_clk each pass through SYNC_STAGES flops plus one history flop, used for rise and fall detection.
- **Latency.** Pin change to pad_data_n change is SYNC_STAGES + 1 clk cycles. All outputs are registered.
- **Wire order and polarity.** Bit 0 is sent first. Order: B, Y, select, start, up, down, left, right, A, X, L1, R1, then four 1s (the four 1s are the fixed "not pressed" ID bits). Each button bit is the inverse of its key bit.
- **State IDLE.** pad_data_n = 1, busy = 0. pad_clk edges are ignored.
- **Synced latch high (any state).** Enter LATCH.
  - Shift register reloads from key every cycle, so it tracks live input.
  - bit_idx = 0, busy = 0, pad_data_n = ~key[5] (B).
- **Synced latch fall.** Enter SHIFT, busy = 1. The key value loaded on the last latch-high cycle is frozen; later key changes have no effect until the next latch.
- **State SHIFT, synced pad_clk rise.**
  - Shift register moves one position toward bit 0 and fills with 0.
  - bit_idx increments and pad_data_n takes the new bit 0.
  - When bit_idx reaches 16: enter DONE, busy = 0, pad_data_n = 0.
- **State DONE.** pad_data_n holds 0 and bit_idx holds 16. Further pad_clk rises are ignored. Only a new latch leaves DONE.
- **Latch and clock priority.**
  - A pad_clk rise while the synced latch is high is ignored; latch wins.
  - If latch rises in the same cycle as a pad_clk rise, latch wins: reload, bit_idx = 0.
- **Re-latch.** A latch mid-SHIFT abandons the transfer and restarts from bit 0.
- **Clock while latch falls.** A pad_clk rise in the same synced cycle as the latch fall is ignored; the first shift needs a later rise.
- **Edge count.** Exactly one shift per synced rise; pad_clk high time has no effect.

Test Plan:
- **Reset values.** Drive reset_n = 0 for 3 cycles, with pad_latch = 0 and pad_clk = 1 -> pad_data_n = 1, busy = 0, bit_idx = 0 during reset and after release.
- **Full read.** Set key = 16'h8021 (up, B, start), pulse latch, then apply 16 pad_clk rises.
  - Serial stream bit 0..15 = 0,1,1,0,0,1,1,1,1,1,1,1,1,1,1,1.
  - After the 16th rise: pad_data_n = 0, busy = 0, bit_idx = 16.
  - Extra rises change nothing.
- **Latency.** With SYNC_STAGES = 2, a pad_clk rise -> pad_data_n updates exactly 3 clk cycles later.
- **Live reload, then freeze.**
  - Change key from 0 to 16'h0020 while latch is high -> pad_data_n drops to 0 within SYNC_STAGES + 1 cycles.
  - Change key after the latch falls -> the stream is unaffected.
- **Re-latch mid-transfer.** Latch again after 5 shifts, using new key = 16'h0001 -> bit_idx = 0 and busy = 0 during latch; the stream restarts with up at position 4.
- **Simultaneous events.**
  - Assert latch and pad_clk rise in the same cycle -> bit_idx = 0, no shift.
  - Pulse reset_n during SHIFT at bit_idx = 7 -> IDLE, pad_data_n = 1.
